// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: pointer/flag controller that runs ram_4096 as a FIFO.
// Optional RAM_FIFO_ERR_EN adds sticky overflow/underflow outputs.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int AF_MARGIN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
`ifdef RAM_FIFO_ERR_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_wr_address,
    output logic [ADDR_WIDTH-1:0] ram_rd_address,
    output logic                  ram_write,
    output logic                  ram_read,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
        $error("DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  push_acc;
    logic                  pop_acc;

    // Accept only what the registered flags allow; nothing strobes in reset.
    always_comb begin
        push_acc = push & ~full_q & ~clear & ~reset;
        pop_acc  = pop & ~empty_q & ~clear & ~reset;
    end

    // Pointer, occupancy and flag next-state; clear wins over traffic.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop_valid_d = pop_acc;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            pop_valid_d = 1'b0;
        end
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
        afull_d = (count_d >= AF_CNT);
    end

    // Main state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            pop_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            pop_valid_q <= pop_valid_d;
        end
    end

`ifdef RAM_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky error flags for requests refused by full/empty.
    always_comb begin
        ovf_d = ovf_q | (push & full_q & ~clear);
        udf_d = udf_q | (pop & empty_q & ~clear);
        if (clear) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

    assign ram_write      = push_acc;
    assign ram_read       = pop_acc;
    assign ram_wr_address = wr_ptr_q;
    assign ram_rd_address = rd_ptr_q;
    assign ram_data_in    = push_data;

    assign pop_data    = ram_data_out;
    assign pop_valid   = pop_valid_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: scoreboard bench for ram_fifo_ctrl with a RAM model.
// Build with RAM_FIFO_ERR_EN to also check overflow/underflow.
module tb_ram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        push;
    logic [63:0] push_data;
    logic        pop;
    logic [63:0] pop_data;
    logic        pop_valid;
    logic        full;
    logic        almost_full;
    logic        empty;
    logic [12:0] count;
    logic [63:0] ram_data_in;
    logic [11:0] ram_wr_address;
    logic [11:0] ram_rd_address;
    logic        ram_write;
    logic        ram_read;
    logic [63:0] ram_data_out;
`ifdef RAM_FIFO_ERR_EN
    logic        overflow;
    logic        underflow;
`endif

    ram_fifo_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .push           (push),
        .push_data      (push_data),
        .pop            (pop),
        .pop_data       (pop_data),
        .pop_valid      (pop_valid),
        .full           (full),
        .almost_full    (almost_full),
        .empty          (empty),
        .count          (count),
`ifdef RAM_FIFO_ERR_EN
        .overflow       (overflow),
        .underflow      (underflow),
`endif
        .ram_data_in    (ram_data_in),
        .ram_wr_address (ram_wr_address),
        .ram_rd_address (ram_rd_address),
        .ram_write      (ram_write),
        .ram_read       (ram_read),
        .ram_data_out   (ram_data_out)
    );

    always #5 clk = ~clk;

    // ram_4096 stand-in: synchronous write, one-cycle registered read.
    logic [63:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_write) mem[ram_wr_address] <= ram_data_in;
        if (ram_read) ram_data_out <= mem[ram_rd_address];
    end

    int          nvec = 0;
    int          nerr = 0;
    int          mcount;
    logic [11:0] mwr;
    logic [11:0] mrd;
    logic        mpend;
    logic        movf;
    logic        mudf;
    logic [63:0] sbq[$];
    logic [63:0] dseq = 64'hC0DE_0000_0000_0000;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mcount = 0;
        mwr    = '0;
        mrd    = '0;
        mpend  = 1'b0;
        movf   = 1'b0;
        mudf   = 1'b0;
        sbq.delete();
    endtask

    task automatic check_state();
        logic [63:0] e;
        chk("count", 64'(count), 64'(mcount));
        chk("empty", 64'(empty), 64'(mcount == 0));
        chk("full", 64'(full), 64'(mcount == 4096));
        chk("almost_full", 64'(almost_full), 64'(mcount >= 4092));
        chk("pop_valid", 64'(pop_valid), 64'(mpend));
        if (mpend) begin
            e = sbq.pop_front();
            chk("pop_data", pop_data, e);
        end
`ifdef RAM_FIFO_ERR_EN
        chk("overflow", 64'(overflow), 64'(movf));
        chk("underflow", 64'(underflow), 64'(mudf));
`endif
    endtask

    // One clock of stimulus; starts and ends 1 time unit after posedge.
    task automatic step(input logic p, input logic [63:0] d,
                        input logic q, input logic c);
        logic pa;
        logic qa;
        push = p;
        push_data = d;
        pop = q;
        clear = c;
        #1;
        pa = p && (mcount != 4096) && !c;
        qa = q && (mcount != 0) && !c;
        chk("ram_write", 64'(ram_write), 64'(pa));
        chk("ram_read", 64'(ram_read), 64'(qa));
        if (pa) begin
            chk("wr_addr", 64'(ram_wr_address), 64'(mwr));
            chk("data_in", ram_data_in, d);
        end
        if (qa) chk("rd_addr", 64'(ram_rd_address), 64'(mrd));
        if (c) begin
            model_reset();
        end else begin
            if (p && mcount == 4096) movf = 1'b1;
            if (q && mcount == 0) mudf = 1'b1;
            if (pa) begin
                sbq.push_back(d);
                mwr++;
                mcount++;
            end
            if (qa) begin
                mrd++;
                mcount--;
            end
            mpend = qa;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, dseq, 1'b0, 1'b0);
            dseq++;
        end
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        push = 1'b1;
        pop = 1'b1;
        push_data = 64'h0;
        model_reset();
        #1;
        chk("rst_ram_write", 64'(ram_write), 64'h0);
        chk("rst_ram_read", 64'(ram_read), 64'h0);
        @(posedge clk);
        #1;
        chk("rst_ram_write2", 64'(ram_write), 64'h0);
        check_state();
        reset = 1'b0;
        push = 1'b0;
        pop = 1'b0;

        // Five words in, five out.
        for (int i = 0; i < 5; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
        chk("cnt5", 64'(count), 64'd5);
        pop_n(5);
        chk("empty_after5", 64'(empty), 64'h1);

        // Simultaneous traffic while empty: first pop refused.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, dseq, 1'b1, 1'b0);
            dseq++;
        end
        chk("pp_empty_cnt", 64'(count), 64'd1);
        pop_n(1);

        // Fill to the top, then one more push.
        push_n(4096);
        chk("full_at_4096", 64'(full), 64'h1);
        push_n(1);
`ifdef RAM_FIFO_ERR_EN
        chk("ovf_set", 64'(overflow), 64'h1);
`endif

        // Simultaneous traffic while full: first push refused.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, dseq, 1'b1, 1'b0);
            dseq++;
        end
        chk("pp_full_cnt", 64'(count), 64'd4095);

        // Flush with a push on the same edge.
        step(1'b1, 64'hDEAD, 1'b0, 1'b1);
        chk("clr_cnt", 64'(count), 64'd0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b1);

        // Wrap the write pointer and drain in order.
        push_n(4096);
        pop_n(4000);
        push_n(100);
        chk("wrap_wr_ptr", 64'(ram_wr_address), 64'd100);
        pop_n(196);
        chk("drained", 64'(empty), 64'h1);

        // In-flight pop killed by an asynchronous reset.
        push_n(3);
        push = 1'b0;
        pop = 1'b1;
        clear = 1'b0;
        #2;
        chk("mid_ram_read", 64'(ram_read), 64'h1);
        reset = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'h0);
        chk("arst_empty", 64'(empty), 64'h1);
        chk("arst_pop_valid", 64'(pop_valid), 64'h0);
        chk("arst_ram_read", 64'(ram_read), 64'h0);
        @(posedge clk);
        #1;
        model_reset();
        check_state();
        reset = 1'b0;
        pop = 1'b0;
        push_n(2);
        pop_n(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
